// File: rtl/cordic_sincos_iter.sv
// ---------------------------------------------------------------------------
// cordic_sincos_iter
//
// Iterative CORDIC rotation engine that returns cos and sin of a full-circle
// binary angle. It handles one angle at a time: accept, rotate ITER times,
// finalise, then present the result until the consumer takes it.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   in_valid   angle offered
//   in_ready   engine idle and able to accept an angle
//   in_angle   unsigned binary angle, 2^ANGLE_W == 2*pi
//   out_valid  result available
//   out_ready  consumer accepts the result
//   out_cos    cos(in_angle), signed Q1.(DATA_W-2)
//   out_sin    sin(in_angle), signed Q1.(DATA_W-2)
//
// Build option:
//   CORDIC_ROUND_EN  when defined, the output stage rounds half up before
//                    dropping the guard bits; otherwise it truncates.
// ---------------------------------------------------------------------------
module cordic_sincos_iter #(
  parameter int DATA_W  = 16,
  parameter int ANGLE_W = 32,
  parameter int ITER    = 16,
  parameter int GUARD   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ANGLE_W-1:0] in_angle,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_cos,
  output logic [DATA_W-1:0]  out_sin
);

  localparam int  IW = DATA_W + GUARD + 1;
  // One extra count value marks the finalise cycle after the last rotation.
  localparam int  CW = $clog2(ITER + 1);
  localparam real PI = 3.14159265358979323846;

  // Start magnitude pre-scaled by the CORDIC gain so the result needs no
  // post-multiplication.
  function automatic logic [IW-1:0] calc_x0();
    real k;
    k = 1.0;
    for (int i = 0; i < ITER; i++) begin
      k = k / $sqrt(1.0 + 1.0 / (4.0 ** i));
    end
    return IW'(longint'(k * (2.0 ** (DATA_W - 2 + GUARD))));
  endfunction

  function automatic logic [ITER-1:0][ANGLE_W-1:0] calc_atan_tab();
    logic [ITER-1:0][ANGLE_W-1:0] t;
    for (int i = 0; i < ITER; i++) begin
      t[i] = ANGLE_W'(longint'($atan(1.0 / (2.0 ** i)) / (2.0 * PI) * (2.0 ** ANGLE_W)));
    end
    return t;
  endfunction

  localparam logic signed [IW-1:0]         X0        = calc_x0();
  localparam logic [ITER-1:0][ANGLE_W-1:0] ATAN_TAB  = calc_atan_tab();
  localparam logic [ANGLE_W-1:0]           HALF_TURN = {1'b1, {(ANGLE_W-1){1'b0}}};
  localparam logic signed [IW:0]           SAT_MAX   = {{(GUARD+3){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [IW:0]           SAT_MIN   = -SAT_MAX;
`ifdef CORDIC_ROUND_EN
  localparam logic signed [IW:0]           RND_BIAS  = (IW+1)'(1) <<< (GUARD - 1);
`endif

  // Drop guard bits, undo the quadrant fold and clamp to the symmetric range.
  function automatic logic [DATA_W-1:0] finish_out(input logic signed [IW-1:0] v,
                                                   input logic flip);
    logic signed [IW:0] w;
    w = {v[IW-1], v};
`ifdef CORDIC_ROUND_EN
    w = w + RND_BIAS;
`endif
    w = w >>> GUARD;
    if (flip) begin
      w = -w;
    end else begin
      w = w;
    end
    if (w > SAT_MAX) begin
      return SAT_MAX[DATA_W-1:0];
    end else if (w < SAT_MIN) begin
      return SAT_MIN[DATA_W-1:0];
    end else begin
      return w[DATA_W-1:0];
    end
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                     state_q;
  logic                       in_ready_q;
  logic                       out_valid_q;
  logic [DATA_W-1:0]          out_cos_q;
  logic [DATA_W-1:0]          out_sin_q;
  logic signed [IW-1:0]       x_q, y_q, x_d, y_d;
  logic signed [ANGLE_W-1:0]  z_q, z_d;
  logic [CW-1:0]              cnt_q;
  logic                       neg_q;
  logic [ANGLE_W-1:0]         atan_s;
  logic [ANGLE_W-1:0]         z0_s;
  logic                       neg0_s;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_cos   = out_cos_q;
  assign out_sin   = out_sin_q;

  // Fold the angle into [-pi/2, pi/2); the dropped half turn becomes a sign flip.
  always_comb begin
    case (in_angle[ANGLE_W-1 -: 2])
      2'b00, 2'b11: begin
        z0_s   = in_angle;
        neg0_s = 1'b0;
      end
      default: begin
        z0_s   = in_angle + HALF_TURN;
        neg0_s = 1'b1;
      end
    endcase
  end

  // Arctangent constant for the current micro-rotation (one-hot AND-OR mux).
  always_comb begin
    atan_s = '0;
    for (int i = 0; i < ITER; i++) begin
      atan_s = atan_s | (ATAN_TAB[i] & {ANGLE_W{cnt_q == CW'(i)}});
    end
  end

  // One micro-rotation; direction follows the sign of the residual angle.
  always_comb begin
    if (z_q[ANGLE_W-1] == 1'b0) begin
      x_d = x_q - (y_q >>> cnt_q);
      y_d = y_q + (x_q >>> cnt_q);
      z_d = z_q - atan_s;
    end else begin
      x_d = x_q + (y_q >>> cnt_q);
      y_d = y_q - (x_q >>> cnt_q);
      z_d = z_q + atan_s;
    end
  end

  // Handshake FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_cos_q   <= '0;
      out_sin_q   <= '0;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      neg_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q        <= X0;
            y_q        <= '0;
            z_q        <= z0_s;
            neg_q      <= neg0_s;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ROT;
          end
        end
        ROT: begin
          if (cnt_q == CW'(ITER)) begin
            out_cos_q   <= finish_out(x_q, neg_q);
            out_sin_q   <= finish_out(y_q, neg_q);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            z_q   <= z_d;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          // A simultaneous in_valid is not taken here; the engine re-enters IDLE first.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sincos_iter.sv
module tb_cordic_sincos_iter;

  localparam int  DATA_W  = 16;
  localparam int  ANGLE_W = 32;
  localparam int  ITER    = 16;
  localparam int  GUARD   = 4;
  localparam real PI      = 3.14159265358979323846;
  localparam real SCALE   = 16384.0;
  localparam real TOL     = 4.0;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [ANGLE_W-1:0] in_angle;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_cos;
  logic [DATA_W-1:0]  out_sin;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cordic_sincos_iter #(
    .DATA_W (DATA_W),
    .ANGLE_W(ANGLE_W),
    .ITER   (ITER),
    .GUARD  (GUARD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_angle (in_angle),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_cos  (out_cos),
    .out_sin  (out_sin)
  );

  // Reference: ideal trig of the angle, scaled to Q1.14.
  function automatic real angle_rad(input logic [31:0] a);
    longint la;
    la = longint'({32'd0, a});
    return 2.0 * PI * real'(la) / 4294967296.0;
  endfunction

  function automatic real ref_cos(input logic [31:0] a);
    return $cos(angle_rad(a)) * SCALE;
  endfunction

  function automatic real ref_sin(input logic [31:0] a);
    return $sin(angle_rad(a)) * SCALE;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input logic [15:0] obs, input real exp);
    real  diff;
    logic ok;
    diff = real'($signed(obs)) - exp;
    if (diff < 0.0) diff = -diff;
    ok = (diff <= TOL);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0.1f +/-4", tag, $signed(obs), exp);
    end
  endtask

  // Offer an angle, measure latency, check the result, then consume it.
  task automatic do_txn(input logic [31:0] a, input string tag);
    int lat;
    chk({tag, " in_ready"}, in_ready, 1);
    in_angle = a;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
    chk({tag, " latency"}, lat, ITER + 1);
    chk_near({tag, " cos"}, out_cos, ref_cos(a));
    chk_near({tag, " sin"}, out_sin, ref_sin(a));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, " consumed valid"}, out_valid, 0);
    chk({tag, " consumed ready"}, in_ready, 1);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk({tag, " wait valid"}, out_valid, 1);
  endtask

  logic [31:0] dir_tab [8] = '{32'h0000_0000, 32'h4000_0000, 32'h8000_0000, 32'hE000_0000,
                               32'h1555_5555, 32'hC000_0000, 32'hBFFF_FFFF, 32'h3FFF_FFFF};

  initial begin
    logic [15:0] hold_c;
    logic [15:0] hold_s;
    logic [31:0] a;
    int          n;
    int          vcount;
    logic        seen;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_angle  = '0;
    repeat (3) step();
    rst = 1'b0;
    #1;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_cos", out_cos, 0);
    chk("reset out_sin", out_sin, 0);
    step();

    // Directed angles: zero, quadrant folds, -45 deg, 30 deg, fold boundaries.
    for (int i = 0; i < 8; i++) begin
      do_txn(dir_tab[i], $sformatf("dir%0d", i));
    end

    // Backpressure: result held, busy, stray in_valid ignored.
    in_angle = 32'h0AAA_AAAA;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_valid("bp");
    chk_near("bp cos", out_cos, ref_cos(32'h0AAA_AAAA));
    chk_near("bp sin", out_sin, ref_sin(32'h0AAA_AAAA));
    hold_c = out_cos;
    hold_s = out_sin;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      in_angle = $urandom;
      step();
      chk("bp hold valid", out_valid, 1);
      chk("bp hold ready", in_ready, 0);
      chk("bp hold cos", out_cos, hold_c);
      chk("bp hold sin", out_sin, hold_s);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp release valid", out_valid, 0);
    chk("bp release ready", in_ready, 1);
    seen = 1'b0;
    repeat (25) begin
      step();
      if (out_valid === 1'b1) seen = 1'b1;
    end
    chk("bp no queued job", seen, 0);
    do_txn(32'h2000_0000, "bp next");

    // DONE with in_valid and out_ready both high: consume only, no accept.
    in_angle = 32'h6000_0000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_valid("both");
    chk_near("both cos", out_cos, ref_cos(32'h6000_0000));
    chk_near("both sin", out_sin, ref_sin(32'h6000_0000));
    in_angle  = 32'h1000_0000;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("both valid", out_valid, 0);
    chk("both ready", in_ready, 1);
    seen = 1'b0;
    repeat (25) begin
      step();
      if (out_valid === 1'b1) seen = 1'b1;
    end
    chk("both not accepted", seen, 0);

    // Throughput with out_ready tied high.
    out_ready = 1'b1;
    in_angle  = 32'h5000_0000;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    vcount = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      step();
      n++;
      if (out_valid === 1'b1) vcount++;
    end
    out_ready = 1'b0;
    chk("thru period", n, ITER + 2);
    chk("thru valid cycles", vcount, 1);

    // Reset five cycles after an accept discards the job.
    in_angle = 32'h1234_5678;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    #1;
    chk("midrst in_ready", in_ready, 1);
    chk("midrst out_valid", out_valid, 0);
    chk("midrst out_cos", out_cos, 0);
    chk("midrst out_sin", out_sin, 0);
    #2;
    rst = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      step();
      if (out_valid === 1'b1) seen = 1'b1;
    end
    chk("midrst no result", seen, 0);
    do_txn(32'h2000_0000, "midrst next");

    // Random angles against the ideal trig model.
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      do_txn(a, $sformatf("rand%0d a=%08h", i, a));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
